// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl
// Round-robin front end that time-shares one start/done style multiplier
// (repeated-addition, not resettable) among N requesters. A grant latches the
// winner's operands, pulses mul_s once, lets the multiplier's done flag settle,
// then waits for completion or timeout and returns the product with a
// one-cycle done strobe to the served requester.
module mult_share_ctrl #(
  parameter int N          = 4,
  parameter int W          = 32,
  parameter int SETTLE_CYC = 3,
  parameter int TIMEOUT    = 4095
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_flat,
  input  logic [N*W-1:0] b_flat,
  output logic [N-1:0]   done,
  output logic [W-1:0]   result,
  output logic           err,
  output logic           busy,
  output logic           mul_s,
  output logic [W-1:0]   mul_in1,
  output logic [W-1:0]   mul_in2,
  input  logic           mul_v,
  input  logic [W-1:0]   mul_data
);

  localparam int IDW           = (N > 1) ? $clog2(N) : 1;
  localparam int TW            = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // SETTLE always lasts at least one cycle so a stale done flag is never
  // sampled in the cycle right after the start pulse.
  localparam int SETTLE_LAST_I = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
  localparam int SW            = (SETTLE_LAST_I > 1) ? $clog2(SETTLE_LAST_I + 1) : 1;

  localparam logic [TW-1:0]  TIMEOUT_T   = TW'(TIMEOUT);
  localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_LAST_I);
  localparam logic [IDW-1:0] LAST_ID     = IDW'(N - 1);
  localparam logic [IDW:0]   N_EXT       = (IDW + 1)'(N);

  typedef enum logic [2:0] {
    DRAIN,
    IDLE,
    START,
    SETTLE,
    WAIT,
    DONE
  } state_t;

  state_t         state_reg, state_next;
  logic [IDW-1:0] ptr_reg, ptr_next;
  logic [IDW-1:0] id_reg, id_next;
  logic [W-1:0]   in1_reg, in1_next;
  logic [W-1:0]   in2_reg, in2_next;
  logic [W-1:0]   result_reg, result_next;
  logic           err_reg, err_next;
  logic           timeout_reg, timeout_next;
  logic [SW-1:0]  settle_reg, settle_next;
  logic [TW-1:0]  timer_reg, timer_next;

  logic [W-1:0]   a_arr [N];
  logic [W-1:0]   b_arr [N];
  logic [N-1:0]   req_rot;
  logic [IDW-1:0] grant_off;
  logic [IDW:0]   grant_sum;
  logic [IDW-1:0] grant_id;
  logic           grant_valid;

  // Per-requester operand slicing, request rotation and done decode.
  // req_rot[k] is the request of requester (ptr + k) mod N, so the lowest set
  // bit of req_rot is the next requester in round-robin order.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi = gi + 1) begin : g_req
      localparam logic [IDW-1:0] GI_ID  = IDW'(gi);
      localparam logic [IDW:0]   GI_EXT = (IDW + 1)'(gi);
      logic [IDW:0] rot_sum;

      assign a_arr[gi] = a_flat[gi*W +: W];
      assign b_arr[gi] = b_flat[gi*W +: W];
      assign done[gi]  = (state_reg == DONE) && (id_reg == GI_ID);

      // rotate the request vector by the round-robin pointer
      always_comb begin
        rot_sum = {1'b0, ptr_reg} + GI_EXT;
        if (rot_sum >= N_EXT) rot_sum = rot_sum - N_EXT;
      end

      assign req_rot[gi] = req[rot_sum[IDW-1:0]];
    end
  endgenerate

  // pick the first active requester at or after the pointer (mod N)
  always_comb begin
    grant_valid = |req_rot;
    grant_off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) grant_off = IDW'(k);
    end
    grant_sum = {1'b0, ptr_reg} + {1'b0, grant_off};
    if (grant_sum >= N_EXT) grant_sum = grant_sum - N_EXT;
    grant_id = grant_sum[IDW-1:0];
  end

  // next-state and datapath update for the scheduler FSM
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    id_next      = id_reg;
    in1_next     = in1_reg;
    in2_next     = in2_reg;
    result_next  = result_reg;
    err_next     = err_reg;
    timeout_next = timeout_reg;
    settle_next  = settle_reg;
    timer_next   = timer_reg;

    case (state_reg)
      // The multiplier keeps running across our reset and ignores a start
      // while busy, so let any in-flight operation finish before serving.
      DRAIN: begin
        if (mul_v || (timer_reg == TIMEOUT_T)) begin
          state_next = IDLE;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      IDLE: begin
        if (grant_valid) begin
          id_next    = grant_id;
          in1_next   = a_arr[grant_id];
          in2_next   = b_arr[grant_id];
          state_next = START;
        end
      end

      START: begin
        settle_next = '0;
        state_next  = SETTLE;
      end

      // mul_v may still be high from the previous product here; ignore it.
      SETTLE: begin
        if (settle_reg == SETTLE_LAST) begin
          timer_next = '0;
          state_next = WAIT;
        end else begin
          settle_next = settle_reg + 1'b1;
        end
      end

      WAIT: begin
        if (mul_v) begin
          result_next  = mul_data;
          err_next     = 1'b0;
          timeout_next = 1'b0;
          state_next   = DONE;
        end else if (timer_reg == TIMEOUT_T) begin
          result_next  = '0;
          err_next     = 1'b1;
          timeout_next = 1'b1;
          state_next   = DONE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      // A timed-out multiplier is still busy, so drain it before the next grant.
      DONE: begin
        ptr_next     = (id_reg == LAST_ID) ? '0 : id_reg + 1'b1;
        timer_next   = '0;
        timeout_next = 1'b0;
        state_next   = timeout_reg ? DRAIN : IDLE;
      end

      default: begin
        state_next = DRAIN;
        timer_next = '0;
      end
    endcase
  end

  // state and datapath registers, asynchronously cleared into DRAIN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= DRAIN;
      ptr_reg     <= '0;
      id_reg      <= '0;
      in1_reg     <= '0;
      in2_reg     <= '0;
      result_reg  <= '0;
      err_reg     <= 1'b0;
      timeout_reg <= 1'b0;
      settle_reg  <= '0;
      timer_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      id_reg      <= id_next;
      in1_reg     <= in1_next;
      in2_reg     <= in2_next;
      result_reg  <= result_next;
      err_reg     <= err_next;
      timeout_reg <= timeout_next;
      settle_reg  <= settle_next;
      timer_reg   <= timer_next;
    end
  end

  assign result  = result_reg;
  assign err     = err_reg;
  assign mul_in1 = in1_reg;
  assign mul_in2 = in2_reg;
  assign mul_s   = (state_reg == START);
  assign busy    = (state_reg != IDLE);

endmodule
